maxpool2d_stream: RTL and testbench
===================================

// Module: maxpool2d_stream
// PURPOSE
//  Streaming successor to the combinational pooling stage: accepts one pixel (all CH channels in parallel) per
//  cycle in raster order (row-major, h outer, w inner) over valid/ready. It emits pooled pixels in raster order
//  with the same handshake. Per-column partial accumulators replace whole-frame flattened vectors, so large
//  feature maps fit between conv/activation stages. It supports non-square maps, stride >= window, and an optional average mode.
// PARAMETERS
//  CH        1       channels per pixel, processed in lockstep
//  IN_H      8       input rows per frame
//  IN_W      8       input columns per frame
//  K         2       pooling window (K x K)
//  STRIDE    2       window step; STRIDE < K is an elaboration-time $error
//  WIDTH     16      signed element width (two's complement)
//  precision "Q8.8"  fixed-point tag; informational only, no effect on arithmetic
//  Derived: OUT_H=(IN_H-K)/STRIDE+1, OUT_W=(IN_W-K)/STRIDE+1; no padding.
//  Rows/cols beyond the last full window are consumed and discarded.
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-high
//  in_valid   in   1         in_data valid
//  in_ready   out  1         block can accept in_data this cycle
//  in_data    in   CH*WIDTH  channel c at [c*WIDTH +: WIDTH]
//  out_valid  out  1         out_data valid
//  out_ready  in   1         downstream accepts out_data
//  out_data   out  CH*WIDTH  pooled pixel, same channel packing
//  out_last   out  1         qualifies out_valid: last pooled pixel of a frame
//  avg_mode   in   1         only with POOL_AVG_EN: 1 = average, 0 = max; sample at frame start
// BEHAVIOUR
//  - Reset: in_ready=0 while rst is high, 1 from the first edge after release. out_valid=0, out_data=0,
//    out_last=0. Row/col counters=0. Accumulators cleared.
//  - Reset mid-frame discards all partial windows. The next accepted pixel is (0,0).
//  - Input transfer: in_valid&&in_ready. Output transfer: out_valid&&out_ready.
//  - out_data/out_last hold stable while out_valid&&!out_ready.
//  - in_ready = !out_valid || out_ready. A completing window is never dropped.
//  - Throughput: 1 pixel/cycle.
//  - Counters: col increments per input transfer. At col==IN_W-1, col wraps to 0 and row increments.
//    At (IN_H-1,IN_W-1), both wrap to 0; the next frame follows back-to-back with no bubble.
//  - Window membership: r=row-oh*STRIDE and c=col-ow*STRIDE must both lie in [0,K), with oh<OUT_H and ow<OUT_W.
//  - Accumulator acc[ch][ow]. At (r,c)==(0,0), acc loads the element.
//    Otherwise acc=max(acc,x) using signed compare; ties keep either (equal).
//  - Completion: at (r,c)==(K-1,K-1), the result is written to the output register, not to acc.
//    out_valid rises the next cycle, so latency is 1 cycle from the last window pixel transfer.
//  - out_last=1 with the result of window (OUT_H-1,OUT_W-1).
//  - Simultaneous output transfer and window completion in the same cycle: the output register reloads and
//    out_valid stays 1.
//  - Pixels outside every window update nothing but still advance the counters.
// CONFIGURATION
//  POOL_AVG_EN defined:
//   - avg_mode port exists; the mode is latched on the transfer of pixel (0,0).
//   - K must be a power of two, else $error.
//   - Sum width is WIDTH+$clog2(K*K), sign-extended per element.
//   - Result = sum >>> $clog2(K*K): arithmetic shift, rounds toward -inf, then truncated to WIDTH
//     (always in range).
//  POOL_AVG_EN undefined: no avg_mode port, max only, accumulators WIDTH wide.
// TESTING
//  1. CH=1,IN=4x4,K=2,S=2, input values 0..15 raster, out_ready=1 -> outputs 5,7,13,15; out_last only on 15;
//     each output 1 cycle after its window's last pixel.
//  2. Negative values: all inputs -32768 except one -1 per window -> every output -1 (0xFFFF).
//  3. Backpressure: out_ready=0 for 5 cycles after first output -> in_ready=0 while stalled, out_data held,
//     no output lost/duplicated, sequence identical to test 1.
//  4. IN=5x5,K=2,S=2, values 0..24 raster -> 4 outputs 6,8,16,18; row/col 4 discarded; the next frame starts
//     at (0,0) back-to-back.
//  5. Assert rst mid-frame after 6 pixels -> out_valid=0 immediately; re-sending full test-1 frame -> 5,7,13,15.
//  6. POOL_AVG_EN, avg_mode=1, K=2, window {-3,-2,-1,1} -> sum -5 >>> 2 = -2; CH=2 lanes checked independently.

Source files
------------

// File: rtl/maxpool2d_stream.sv
// Streaming K x K pooling over a raster pixel stream, one pixel (CH lanes) per cycle.
// Define POOL_AVG_EN to add the avg_mode_i port and average pooling.
module maxpool2d_stream #(
  parameter int unsigned CH        = 1,
  parameter int unsigned IN_H      = 8,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned K         = 2,
  parameter int unsigned STRIDE    = 2,
  parameter int unsigned WIDTH     = 16,
  parameter string       PRECISION = "Q8.8"
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CH*WIDTH-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CH*WIDTH-1:0] out_data_o,
  output logic                out_last_o
`ifdef POOL_AVG_EN
  ,
  input  logic                avg_mode_i
`endif
);

  localparam int unsigned OUT_H = (IN_H - K) / STRIDE + 1;
  localparam int unsigned OUT_W = (IN_W - K) / STRIDE + 1;
`ifdef POOL_AVG_EN
  localparam int unsigned Shift = $clog2(K * K);
`else
  localparam int unsigned Shift = 0;
`endif
  localparam int unsigned AccW = WIDTH + Shift;
  localparam int unsigned ColW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned RowW = (IN_H > 1) ? $clog2(IN_H) : 1;
  // Phase counters must also represent K itself for the membership compare.
  localparam int unsigned PhW  = $clog2(STRIDE + 1);
  localparam int unsigned OhW  = $clog2(IN_H / STRIDE + 2);
  localparam int unsigned OwW  = $clog2(IN_W / STRIDE + 2);
  localparam int unsigned IdxW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (STRIDE < K) begin : g_bad_stride
    $error("maxpool2d_stream: STRIDE must be >= K");
  end
  if (IN_H < K || IN_W < K) begin : g_bad_size
    $error("maxpool2d_stream: input map smaller than window");
  end
  if (PRECISION == "") begin : g_bad_prec
    $error("maxpool2d_stream: empty precision tag");
  end
`ifdef POOL_AVG_EN
  if ((K & (K - 1)) != 0) begin : g_bad_k
    $error("maxpool2d_stream: K must be a power of two for averaging");
  end
`endif

  typedef logic signed [AccW-1:0] acc_t;

  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [PhW-1:0]      cph_q, cph_d, rph_q, rph_d;
  logic [OwW-1:0]      ow_q, ow_d;
  logic [OhW-1:0]      oh_q, oh_d;
  logic                rdy_q;
  acc_t                acc_q [OUT_W][CH];
  acc_t                x_ext [CH];
  acc_t                comb  [CH];
  logic [CH*WIDTH-1:0] res, out_data_q;
  logic                out_valid_q, out_last_q;
  logic                in_fire, in_win, win_first, win_last, frame_last, avg_eff;
  logic [IdxW-1:0]     idx;

  assign in_ready_o  = rdy_q && (!out_valid_q || out_ready_i);
  assign in_fire     = in_valid_i && in_ready_o;
  assign in_win      = (rph_q < PhW'(K)) && (cph_q < PhW'(K)) &&
                       (oh_q < OhW'(OUT_H)) && (ow_q < OwW'(OUT_W));
  assign win_first   = (rph_q == '0) && (cph_q == '0);
  assign win_last    = (rph_q == PhW'(K - 1)) && (cph_q == PhW'(K - 1));
  assign frame_last  = (oh_q == OhW'(OUT_H - 1)) && (ow_q == OwW'(OUT_W - 1));
  assign idx         = IdxW'(ow_q);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_valid_q && out_last_q;

`ifdef POOL_AVG_EN
  logic avg_q;
  // Pixel (0,0) uses the live mode; later pixels use the value latched with it.
  assign avg_eff = (row_q == '0 && col_q == '0) ? avg_mode_i : avg_q;
`else
  assign avg_eff = 1'b0;
`endif

  always_comb begin
    res = '0;
    for (int c = 0; c < CH; c++) begin
      x_ext[c] = acc_t'($signed(in_data_i[c*WIDTH +: WIDTH]));
      if (win_first) begin
        comb[c] = x_ext[c];
      end else if (avg_eff) begin
        comb[c] = acc_q[idx][c] + x_ext[c];
      end else begin
        comb[c] = (x_ext[c] > acc_q[idx][c]) ? x_ext[c] : acc_q[idx][c];
      end
      res[c*WIDTH +: WIDTH] = avg_eff ? WIDTH'(comb[c] >>> Shift) : WIDTH'(comb[c]);
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    ow_d  = ow_q;
    oh_d  = oh_q;
    if (in_fire) begin
      if (col_q == ColW'(IN_W - 1)) begin
        col_d = '0;
        cph_d = '0;
        ow_d  = '0;
        if (row_q == RowW'(IN_H - 1)) begin
          row_d = '0;
          rph_d = '0;
          oh_d  = '0;
        end else begin
          row_d = row_q + 1'b1;
          if (rph_q == PhW'(STRIDE - 1)) begin
            rph_d = '0;
            oh_d  = oh_q + 1'b1;
          end else begin
            rph_d = rph_q + 1'b1;
          end
        end
      end else begin
        col_d = col_q + 1'b1;
        if (cph_q == PhW'(STRIDE - 1)) begin
          cph_d = '0;
          ow_d  = ow_q + 1'b1;
        end else begin
          cph_d = cph_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      cph_q       <= '0;
      rph_q       <= '0;
      ow_q        <= '0;
      oh_q        <= '0;
      rdy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef POOL_AVG_EN
      avg_q       <= 1'b0;
`endif
      for (int o = 0; o < OUT_W; o++) begin
        for (int c = 0; c < CH; c++) begin
          acc_q[o][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cph_q <= cph_d;
      rph_q <= rph_d;
      ow_q  <= ow_d;
      oh_q  <= oh_d;
      rdy_q <= 1'b1;
`ifdef POOL_AVG_EN
      if (in_fire && row_q == '0 && col_q == '0) begin
        avg_q <= avg_mode_i;
      end
`endif
      if (in_fire && in_win && !win_last) begin
        for (int c = 0; c < CH; c++) begin
          acc_q[idx][c] <= comb[c];
        end
      end
      // in_fire implies the output register is free or draining this cycle.
      if (in_fire && in_win && win_last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
        out_last_q  <= frame_last;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Bench for maxpool2d_stream: a 4x4 and a 5x5 instance (CH=2, K=2, S=2) checked against
// a window-level reference model, plus cycle tables for latency and reset corners.
module tb_maxpool2d_stream;

  localparam int unsigned CH     = 2;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned K      = 2;
  localparam int unsigned STRIDE = 2;
  localparam int unsigned DW     = CH * WIDTH;
  localparam int          MaxPix = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sel;
  logic          in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_out_last;
  logic          b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_out_last;
  logic [DW-1:0] a_out_data, b_out_data;
  logic          in_ready, out_valid, out_last;
  logic [DW-1:0] out_data;
`ifdef POOL_AVG_EN
  logic          avg_mode;
`endif

  assign a_in_valid  = in_valid && !sel;
  assign b_in_valid  = in_valid && sel;
  assign a_out_ready = sel ? 1'b1 : out_ready;
  assign b_out_ready = sel ? out_ready : 1'b1;
  assign in_ready    = sel ? b_in_ready : a_in_ready;
  assign out_valid   = sel ? b_out_valid : a_out_valid;
  assign out_last    = sel ? b_out_last : a_out_last;
  assign out_data    = sel ? b_out_data : a_out_data;

  maxpool2d_stream #(
    .CH(CH), .IN_H(4), .IN_W(4), .K(K), .STRIDE(STRIDE), .WIDTH(WIDTH)
  ) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (a_in_valid),
    .in_ready_o  (a_in_ready),
    .in_data_i   (in_data),
    .out_valid_o (a_out_valid),
    .out_ready_i (a_out_ready),
    .out_data_o  (a_out_data),
    .out_last_o  (a_out_last)
`ifdef POOL_AVG_EN
    ,
    .avg_mode_i  (avg_mode)
`endif
  );

  maxpool2d_stream #(
    .CH(CH), .IN_H(5), .IN_W(5), .K(K), .STRIDE(STRIDE), .WIDTH(WIDTH)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (in_data),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_data_o  (b_out_data),
    .out_last_o  (b_out_last)
`ifdef POOL_AVG_EN
    ,
    .avg_mode_i  (avg_mode)
`endif
  );

  int            errors = 0;
  int            checks = 0;
  bit            sb_en  = 1'b0;
  int            frame [CH][MaxPix];
  logic [DW-1:0] exp_data_q [$];
  logic          exp_last_q [$];

  typedef struct {
    int d0;
    int d1;
    bit ev;
    int e0;
    int e1;
    bit el;
  } vec_t;
  vec_t tbl [16];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each output is the max (or floor mean) over its K x K window.
  task automatic model_frame(input int h, input int w, input bit avg);
    int oh_n, ow_n, kk;
    logic [DW-1:0] d;
    oh_n = (h - K) / STRIDE + 1;
    ow_n = (w - K) / STRIDE + 1;
    kk   = K * K;
    for (int oh = 0; oh < oh_n; oh++) begin
      for (int ow = 0; ow < ow_n; ow++) begin
        d = '0;
        for (int c = 0; c < CH; c++) begin
          int best, sum, v, q;
          best = frame[c][oh * STRIDE * w + ow * STRIDE];
          sum  = 0;
          for (int r = 0; r < K; r++) begin
            for (int cc = 0; cc < K; cc++) begin
              v = frame[c][(oh * STRIDE + r) * w + ow * STRIDE + cc];
              if (v > best) best = v;
              sum += v;
            end
          end
          q = sum / kk;
          if (sum < 0 && q * kk != sum) q--;
          d[c*WIDTH +: WIDTH] = avg ? q[WIDTH-1:0] : best[WIDTH-1:0];
        end
        exp_data_q.push_back(d);
        exp_last_q.push_back(oh == oh_n - 1 && ow == ow_n - 1);
      end
    end
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) begin
      frame[0][i] = i;
      frame[1][i] = n - 1 - i;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < n; i++) begin
        frame[c][i] = int'($urandom_range(0, 65535)) - 32768;
      end
    end
  endtask

  task automatic drive_pixel(input int i);
    int v;
    for (int c = 0; c < CH; c++) begin
      v = frame[c][i];
      in_data[c*WIDTH +: WIDTH] = v[WIDTH-1:0];
    end
  endtask

  // vmode: 0 valid always, 1 random. rmode: 0 ready always, 1 random, 2 stall 5 cycles on 1st output.
  task automatic stream_frame(input int h, input int w, input int vmode, input int rmode);
    int i, guard, stalls;
    bit fire;
    i = 0; guard = 0; stalls = 0;
    while (i < h * w && guard < 4000) begin
      in_valid = (vmode == 0) || ($urandom_range(0, 3) != 0);
      drive_pixel(i);
      if (rmode == 0) begin
        out_ready = 1'b1;
      end else if (rmode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else if (out_valid && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
`ifdef POOL_AVG_EN
      if (i > 0) avg_mode = 1'($urandom_range(0, 1));
`endif
      #1;
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) i++;
      guard++;
    end
    checks++;
    if (i < h * w) begin
      errors++;
      $display("FAIL stream_timeout: got %0d pixels accepted expected %0d", i, h * w);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_data_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs missing expected 0", exp_data_q.size());
    end
    @(posedge clk); #1;
    check1("idle_after_drain", out_valid, 1'b0);
  endtask

  // Scoreboard: compares transfers in order and checks holding while stalled.
  bit            stall_seen = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  logic [DW-1:0] ed;
  logic          el;
  always @(negedge clk) begin
    if (rst || !sb_en) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_last !== held_last) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   out_valid, out_data, out_last, held_data, held_last);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL extra_output: got %h expected no output", out_data);
        end else begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          if (out_data !== ed || out_last !== el) begin
            errors++;
            $display("FAIL output: got d=%h l=%b expected d=%h l=%b", out_data, out_last, ed, el);
          end
        end
      end
      stall_seen = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] e;
    int idx, pos;
    sel       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
`ifdef POOL_AVG_EN
    avg_mode  = 1'b0;
`endif
    for (int i = 0; i < 16; i++) tbl[i] = '{i, 15 - i, 1'b0, 0, 0, 1'b0};
    tbl[5]  = '{5, 10, 1'b1, 5, 15, 1'b0};
    tbl[7]  = '{7, 8, 1'b1, 7, 13, 1'b0};
    tbl[13] = '{13, 2, 1'b1, 13, 7, 1'b0};
    tbl[15] = '{15, 0, 1'b1, 15, 5, 1'b1};

    // Reset state
    #12;
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    checkd("rst_out_data", out_data, '0);
    check1("rst_out_last", out_last, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check1("rel_in_ready_low", in_ready, 1'b0);
    @(posedge clk); #1;
    check1("rel_in_ready_high", in_ready, 1'b1);

    // 4x4 ramp, cycle-exact latency table
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = {16'(tbl[i].d1), 16'(tbl[i].d0)};
      @(posedge clk); #1;
      check1("t1_valid", out_valid, tbl[i].ev);
      check1("t1_last", out_last, tbl[i].el);
      if (tbl[i].ev) checkd("t1_data", out_data, {16'(tbl[i].e1), 16'(tbl[i].e0)});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    sb_en = 1'b1;

    // Backpressure on the ramp frame
    fill_ramp(16);
    model_frame(4, 4, 1'b0);
    stream_frame(4, 4, 0, 2);
    drain();

    // One -1 per window among -32768
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < 16; i++) frame[c][i] = -32768;
      for (int oh = 0; oh < 2; oh++) begin
        for (int ow = 0; ow < 2; ow++) begin
          pos = int'($urandom_range(0, 3));
          idx = (oh * 2 + pos / 2) * 4 + ow * 2 + pos % 2;
          frame[c][idx] = -1;
        end
      end
    end
    model_frame(4, 4, 1'b0);
    for (int j = 0; j < 4; j++) begin
      e = exp_data_q[j];
      checkd("neg_model", e, {DW{1'b1}});
    end
    stream_frame(4, 4, 1, 1);
    drain();

    // Random back-to-back frames on the 4x4 instance
    for (int f = 0; f < 4; f++) begin
      fill_rand(16);
      model_frame(4, 4, 1'b0);
      stream_frame(4, 4, (f % 2), 1);
    end
    drain();

    // Reset mid-frame after 6 pixels, holding the first output
    sb_en     = 1'b0;
    out_ready = 1'b0;
    fill_ramp(16);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      drive_pixel(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check1("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check1("mid_rst_in_ready", in_ready, 1'b0);
    exp_data_q.delete();
    exp_last_q.delete();
    @(posedge clk); #1;
    rst   = 1'b0;
    sb_en = 1'b1;
    model_frame(4, 4, 1'b0);
    stream_frame(4, 4, 0, 0);
    drain();

    // 5x5 instance: trailing row/col discarded, frames back-to-back
    sel = 1'b1;
    fill_ramp(25);
    model_frame(5, 5, 1'b0);
    stream_frame(5, 5, 0, 0);
    fill_ramp(25);
    model_frame(5, 5, 1'b0);
    stream_frame(5, 5, 0, 0);
    for (int f = 0; f < 3; f++) begin
      fill_rand(25);
      model_frame(5, 5, 1'b0);
      stream_frame(5, 5, (f % 2), 1);
    end
    drain();
    sel = 1'b0;

`ifdef POOL_AVG_EN
    // Average mode: lane 0 windows {-3,-2,-1,1}, lane 1 random
    for (int i = 0; i < 16; i++) begin
      pos = ((i / 4) % 2) * 2 + (i % 2);
      frame[0][i] = (pos == 0) ? -3 : (pos == 1) ? -2 : (pos == 2) ? -1 : 1;
      frame[1][i] = int'($urandom_range(0, 65535)) - 32768;
    end
    avg_mode = 1'b1;
    model_frame(4, 4, 1'b1);
    stream_frame(4, 4, 0, 0);
    drain();
    for (int f = 0; f < 4; f++) begin
      fill_rand(16);
      avg_mode = 1'($urandom_range(0, 1));
      model_frame(4, 4, avg_mode);
      stream_frame(4, 4, 1, 1);
    end
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
